// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: requester, shared-adder and response signals of adder_seq_ctrl.
// The subtract-select inputs exist only when ADDER_SEQ_SUB_EN is defined.
interface adder_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
`ifdef ADDER_SEQ_SUB_EN
    logic         req0_sub;
    logic         req1_sub;
`endif
    logic [7:0]   add_x;
    logic [7:0]   add_y;
    logic         add_c0;
    logic [7:0]   add_s;
    logic         add_c8;
    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         busy;

    modport master (
`ifdef ADDER_SEQ_SUB_EN
        output req0_sub, req1_sub,
`endif
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  add_x, add_y, add_c0,
        output add_s, add_c8,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
`ifdef ADDER_SEQ_SUB_EN
        input  req0_sub, req1_sub,
`endif
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output add_x, add_y, add_c0,
        input  add_s, add_c8,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: round-robin arbiter for two requesters feeding a W-bit add that is
// computed one byte per cycle on a shared external 8-bit adder (IDLE -> RUN x NBYTES -> DONE).
// Defining ADDER_SEQ_SUB_EN adds per-request subtract select (a + ~b + 1).
module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input logic             clk,
    input logic             rst_n,
    adder_seq_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic          cin_q, cin_d;
    logic          id_q, id_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  rsp_sum_q, rsp_sum_d;
    logic          rsp_cout_q, rsp_cout_d;
    logic          rsp_id_q, rsp_id_d;
`ifdef ADDER_SEQ_SUB_EN
    logic          sub_q, sub_d;
`endif
    logic          gnt0, gnt1;
    logic          run;
    logic          sub_op;
    logic [7:0]    a_byte, b_byte;

    // Grant one requester in IDLE (ties go to the one not served last) and drive the adder lane for byte k during RUN
    always_comb begin
`ifdef ADDER_SEQ_SUB_EN
        sub_op = sub_q;
`else
        sub_op = 1'b0;
`endif
        run            = state_q == RUN;
        gnt0           = rst_n && state_q == IDLE && bus.req0_valid && (!bus.req1_valid || last_q);
        gnt1           = rst_n && state_q == IDLE && bus.req1_valid && (!bus.req0_valid || !last_q);
        a_byte         = a_q[{k_q, 3'b000} +: 8];
        b_byte         = b_q[{k_q, 3'b000} +: 8];
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        bus.add_x      = run ? a_byte : 8'h00;
        bus.add_y      = run ? (sub_op ? ~b_byte : b_byte) : 8'h00;
        bus.add_c0     = run && (k_q == '0 ? (sub_op || cin_q) : carry_q);
        bus.busy       = state_q != IDLE;
        bus.rsp_valid  = state_q == DONE;
        bus.rsp_id     = rsp_id_q;
        bus.rsp_sum    = rsp_sum_q;
        bus.rsp_cout   = rsp_cout_q;
    end

    // Next state: latch the granted operation, accumulate one sum byte per RUN beat, publish the result on the last beat
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        k_d        = k_q;
        carry_d    = carry_q;
        cin_d      = cin_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
`ifdef ADDER_SEQ_SUB_EN
        sub_d      = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d     = gnt1 ? bus.req1_b : bus.req0_b;
                    cin_d   = gnt1 ? bus.req1_cin : bus.req0_cin;
`ifdef ADDER_SEQ_SUB_EN
                    sub_d   = gnt1 ? bus.req1_sub : bus.req0_sub;
`endif
                    id_d    = gnt1;
                    last_d  = gnt1;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[{k_q, 3'b000} +: 8] = bus.add_s;
                carry_d = bus.add_c8;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    rsp_sum_d  = acc_d;
                    rsp_cout_d = bus.add_c8;
                    rsp_id_d   = id_q;
                    state_d    = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            k_q        <= '0;
            carry_q    <= 1'b0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
            sub_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            k_q        <= k_d;
            carry_q    <= carry_d;
            cin_q      <= cin_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
`ifdef ADDER_SEQ_SUB_EN
            sub_q      <= sub_d;
`endif
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed checks of arbitration, byte-serial add timing, reset abort and optional subtract.
module tb_adder_seq_ctrl;
    localparam int NBYTES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    adder_seq_ctrl_if #(.NBYTES(NBYTES)) bus ();
    adder_seq_ctrl #(.NBYTES(NBYTES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared external 8-bit adder
    assign {bus.add_c8, bus.add_s} = bus.add_x + bus.add_y + bus.add_c0;

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'h1; bus.req0_b = 32'h1; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h2; bus.req1_b = 32'h2; bus.req1_cin = 1'b0;
        nxt(); nxt(); #1;
        n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready0: got %0b want 0", bus.req0_ready); else n_pass++;
        n_checks++; if (bus.req1_ready !== 1'b0) $display("FAIL reset_ready1: got %0b want 0", bus.req1_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_sum !== 32'h0) $display("FAIL reset_rsp_sum: got %h want 0", bus.rsp_sum); else n_pass++;
        n_checks++; if (bus.rsp_cout !== 1'b0 || bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_cout_id: got %0b/%0b want 0/0", bus.rsp_cout, bus.rsp_id); else n_pass++;
        n_checks++; if (bus.add_x !== 8'h0 || bus.add_y !== 8'h0 || bus.add_c0 !== 1'b0) $display("FAIL reset_adder_bus: got %h/%h/%0b want 0/0/0", bus.add_x, bus.add_y, bus.add_c0); else n_pass++;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        nxt();
    endtask

    task automatic test_single_add();
        logic [7:0] exp_x [4];
        logic [7:0] exp_y [4];
        logic [3:0] exp_c0;
        exp_x = '{8'hFF, 8'h00, 8'h00, 8'h00};
        exp_y = '{8'h01, 8'h00, 8'h00, 8'h00};
        exp_c0 = 4'b0010;
        bus.req0_a = 32'h0000_00FF; bus.req0_b = 32'h0000_0001; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL add_grant: got %0b%0b want 10", bus.req0_ready, bus.req1_ready); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (k == 0) bus.req0_valid = 1'b0;
            #1;
            n_checks++; if (bus.busy !== 1'b1 || bus.req0_ready !== 1'b0) $display("FAIL add_busy_beat%0d: got busy %0b ready %0b want 1/0", k, bus.busy, bus.req0_ready); else n_pass++;
            n_checks++; if (bus.add_c0 !== exp_c0[k]) $display("FAIL add_c0_beat%0d: got %0b want %0b", k, bus.add_c0, exp_c0[k]); else n_pass++;
            n_checks++; if (bus.add_x !== exp_x[k] || bus.add_y !== exp_y[k]) $display("FAIL add_xy_beat%0d: got %h/%h want %h/%h", k, bus.add_x, bus.add_y, exp_x[k], exp_y[k]); else n_pass++;
            n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL add_early_rsp_beat%0d: got %0b want 0", k, bus.rsp_valid); else n_pass++;
        end
        nxt(); #1;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %0b want 1", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_sum !== 32'h0000_0100) $display("FAIL add_rsp_sum: got %h want 00000100", bus.rsp_sum); else n_pass++;
        n_checks++; if (bus.rsp_cout !== 1'b0 || bus.rsp_id !== 1'b0) $display("FAIL add_rsp_cout_id: got %0b/%0b want 0/0", bus.rsp_cout, bus.rsp_id); else n_pass++;
        n_checks++; if (bus.add_x !== 8'h0 || bus.add_c0 !== 1'b0) $display("FAIL add_done_bus: got %h/%0b want 0/0", bus.add_x, bus.add_c0); else n_pass++;
        nxt(); #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL add_after_done: got valid %0b busy %0b want 0/0", bus.rsp_valid, bus.busy); else n_pass++;
        n_checks++; if (bus.rsp_sum !== 32'h0000_0100) $display("FAIL add_sum_hold: got %h want 00000100", bus.rsp_sum); else n_pass++;
    endtask

    task automatic test_carry_out();
        bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'h0; bus.req1_cin = 1'b1; bus.req1_valid = 1'b1;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) $display("FAIL cout_grant: got %0b%0b want 01", bus.req0_ready, bus.req1_ready); else n_pass++;
        nxt(); bus.req1_valid = 1'b0;
        nxt(); nxt(); #1;
        n_checks++; if (bus.rsp_sum !== 32'h0000_0100 || bus.rsp_valid !== 1'b0) $display("FAIL cout_hold_in_run: got %h/%0b want 00000100/0", bus.rsp_sum, bus.rsp_valid); else n_pass++;
        nxt(); nxt(); #1;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL cout_rsp_valid: got %0b want 1", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_sum !== 32'h0) $display("FAIL cout_rsp_sum: got %h want 00000000", bus.rsp_sum); else n_pass++;
        n_checks++; if (bus.rsp_cout !== 1'b1 || bus.rsp_id !== 1'b1) $display("FAIL cout_rsp_cout_id: got %0b/%0b want 1/1", bus.rsp_cout, bus.rsp_id); else n_pass++;
        nxt();
    endtask

    task automatic test_fairness();
        int   last_cyc;
        logic exp;
        last_cyc = 0;
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        bus.req0_a = 32'h1;  bus.req0_b = 32'h2;  bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        bus.req1_a = 32'h10; bus.req1_b = 32'h20; bus.req1_cin = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 1'(i & 1);
            #1;
            n_checks++; if (bus.req0_ready !== !exp || bus.req1_ready !== exp) $display("FAIL fair_grant%0d: got %0b%0b want id %0b", i, bus.req0_ready, bus.req1_ready, exp); else n_pass++;
            repeat (5) nxt();
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp) $display("FAIL fair_rsp%0d: got valid %0b id %0b want 1/%0b", i, bus.rsp_valid, bus.rsp_id, exp); else n_pass++;
            n_checks++; if (bus.rsp_sum !== (exp ? 32'h31 : 32'h3)) $display("FAIL fair_sum%0d: got %h want %h", i, bus.rsp_sum, exp ? 32'h31 : 32'h3); else n_pass++;
            n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) $display("FAIL fair_ready_in_done%0d: got %0b%0b want 00", i, bus.req0_ready, bus.req1_ready); else n_pass++;
            if (i > 0) begin
                n_checks++; if (cyc - last_cyc !== 6) $display("FAIL fair_spacing%0d: got %0d want 6", i, cyc - last_cyc); else n_pass++;
            end
            last_cyc = cyc;
            nxt();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        bus.req0_a = 32'h0102_0304; bus.req0_b = 32'h1020_3040; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        nxt(); bus.req0_valid = 1'b0;
        nxt(); nxt(); #1;
        n_checks++; if (bus.add_x !== 8'h02) $display("FAIL abort_third_beat_x: got %h want 02", bus.add_x); else n_pass++;
        rst_n = 1'b0;
        bus.req0_a = 32'h1234_5678; bus.req0_b = 32'h1111_1111; bus.req0_cin = 1'b1; bus.req0_valid = 1'b1;
        bus.req1_a = 32'h1; bus.req1_b = 32'h1; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        nxt(); #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL abort_state: got busy %0b valid %0b want 0/0", bus.busy, bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) $display("FAIL abort_ready_in_reset: got %0b%0b want 00", bus.req0_ready, bus.req1_ready); else n_pass++;
        n_checks++; if (bus.rsp_sum !== 32'h0) $display("FAIL abort_sum_cleared: got %h want 0", bus.rsp_sum); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL abort_tie_grant: got %0b%0b want 10", bus.req0_ready, bus.req1_ready); else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            nxt();
            if (i == 1) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            end
            #1;
            if (i < 5) begin
                n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL abort_no_pulse%0d: got %0b want 0", i, bus.rsp_valid); else n_pass++;
            end else begin
                n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) $display("FAIL abort_next_rsp: got valid %0b id %0b want 1/0", bus.rsp_valid, bus.rsp_id); else n_pass++;
                n_checks++; if (bus.rsp_sum !== 32'h2345_678A || bus.rsp_cout !== 1'b0) $display("FAIL abort_next_sum: got %h/%0b want 2345678a/0", bus.rsp_sum, bus.rsp_cout); else n_pass++;
            end
        end
        nxt();
    endtask

    task automatic test_back_to_back();
        bus.req1_a = 32'h0000_FFFF; bus.req1_b = 32'h1; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) $display("FAIL b2b_grant1: got %0b want 1", bus.req1_ready); else n_pass++;
        nxt(); bus.req1_valid = 1'b0;
        nxt();
        bus.req0_a = 32'h80FF_7F01; bus.req0_b = 32'h8001_8001; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL b2b_ready_while_busy: got %0b want 0", bus.req0_ready); else n_pass++;
        nxt(); nxt(); nxt(); #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_sum !== 32'h0001_0000) $display("FAIL b2b_rsp1: got %0b/%0b/%h want 1/1/00010000", bus.rsp_valid, bus.rsp_id, bus.rsp_sum); else n_pass++;
        n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL b2b_ready_in_done: got %0b want 0", bus.req0_ready); else n_pass++;
        nxt(); #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL b2b_idle_grant: got ready %0b busy %0b want 1/0", bus.req0_ready, bus.busy); else n_pass++;
        nxt(); bus.req0_valid = 1'b0;
        repeat (4) nxt();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) $display("FAIL b2b_rsp0: got valid %0b id %0b want 1/0", bus.rsp_valid, bus.rsp_id); else n_pass++;
        n_checks++; if (bus.rsp_sum !== 32'h0100_FF02 || bus.rsp_cout !== 1'b1) $display("FAIL b2b_sum0: got %h/%0b want 0100ff02/1", bus.rsp_sum, bus.rsp_cout); else n_pass++;
        nxt();
    endtask

`ifdef ADDER_SEQ_SUB_EN
    task automatic test_sub();
        bus.req0_sub = 1'b1; bus.req0_a = 32'h5; bus.req0_b = 32'h7; bus.req0_cin = 1'b1; bus.req0_valid = 1'b1;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) $display("FAIL sub_grant: got %0b want 1", bus.req0_ready); else n_pass++;
        nxt(); bus.req0_valid = 1'b0; #1;
        n_checks++; if (bus.add_y !== 8'hF8 || bus.add_c0 !== 1'b1) $display("FAIL sub_beat0: got %h/%0b want f8/1", bus.add_y, bus.add_c0); else n_pass++;
        repeat (4) nxt();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'hFFFF_FFFE || bus.rsp_cout !== 1'b0) $display("FAIL sub_5_minus_7: got %0b/%h/%0b want 1/fffffffe/0", bus.rsp_valid, bus.rsp_sum, bus.rsp_cout); else n_pass++;
        nxt();
        bus.req0_a = 32'h7; bus.req0_b = 32'h5; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        nxt(); bus.req0_valid = 1'b0;
        repeat (4) nxt();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h2 || bus.rsp_cout !== 1'b1) $display("FAIL sub_7_minus_5: got %0b/%h/%0b want 1/00000002/1", bus.rsp_valid, bus.rsp_sum, bus.rsp_cout); else n_pass++;
        bus.req0_sub = 1'b0;
        nxt();
    endtask
`endif

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
        bus.req0_sub = 1'b0; bus.req1_sub = 1'b0;
`endif
        test_reset();
        test_single_add();
        test_carry_out();
        test_fairness();
        test_reset_abort();
        test_back_to_back();
`ifdef ADDER_SEQ_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
